// File: rtl/seq_multiplier_32bit.sv
// Unsigned 32x32 -> 64-bit sequential multiplier (MIPS multu semantics).
// Radix-2 shift-add: one multiplier bit retired per clock, 33 edges from accept to done.
module seq_multiplier_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_count;
    logic [63:0] r_prod;
    logic [31:0] r_mcand;

    logic [32:0] w_sum;
    logic [63:0] w_prodNext;

    // The carry-out of the partial-sum add becomes bit 63 after the shift.
    assign w_sum      = r_prod[0] ? ({1'b0, r_prod[63:32]} + {1'b0, r_mcand})
                                  : {1'b0, r_prod[63:32]};
    assign w_prodNext = {w_sum, r_prod[31:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 6'd0;
            r_prod  <= 64'd0;
            r_mcand <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mcand <= a;
                        r_prod  <= {32'd0, b};
                        r_count <= 6'd0;
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    r_prod  <= w_prodNext;
                    r_count <= r_count + 6'd1;
                    // Last multiplier bit: publish the product and leave RUN.
                    if (r_count == 6'd31) begin
                        hi      <= w_prodNext[63:32];
                        lo      <= w_prodNext[31:0];
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Scoreboard bench for seq_multiplier_32bit: stimulus pushes hand-computed products,
// a monitor pops and compares them whenever done pulses.
module tb_seq_multiplier_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [63:0] expQ[$];

    seq_multiplier_32bit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected product.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpectedDone: got hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                logic [63:0] exp;
                exp = expQ.pop_front();
                checkOutput("product", {hi, lo}, exp);
            end
        end
    end

    // Waits for done, checking latency and busy occupancy from the acceptance edge.
    task automatic waitDone(input int firstIdx, input int busySoFar, input string tag);
        int busyCnt;
        int lat;
        bit got;
        busyCnt = busySoFar;
        lat     = 0;
        got     = 0;
        for (int i = firstIdx; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                got = 1;
                lat = i;
            end
        end
        checkOutput({tag, "_latency"}, lat, 33);
        checkOutput({tag, "_busyCycles"}, busyCnt, 32);
    endtask

    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic [63:0] exp, input string tag);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        expQ.push_back(exp);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        waitDone(1, 0, tag);
        @(negedge clk);
        checkOutput({tag, "_doneOneCycle"}, {busy, done}, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_holdHiLo"}, {hi, lo}, exp);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCnt;
        reset = 1'b1;
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        #1;
        checkOutput("resetOutputs", {busy, done, hi, lo}, 66'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("startIgnoredInReset", {busy, done}, 2'b00);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(32'd3,          32'd5,          64'h00000000_0000000F, "mul3x5");
        applyStimulus(32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, "mulMax");
        applyStimulus(32'h12345678,   32'd0,          64'd0,                 "mulBzero");
        applyStimulus(32'd0,          32'hDEADBEEF,   64'd0,                 "mulAzero");
        applyStimulus(32'd1,          32'd1,          64'd1,                 "mul1x1");
        applyStimulus(32'h80000000,   32'd2,          64'h00000001_00000000, "mulCarry");

        // Start held high; operands change during RUN and must not disturb the result.
        @(negedge clk);
        start = 1'b1;
        a     = 32'h00010000;
        b     = 32'h00010001;
        @(posedge clk);
        expQ.push_back(64'h00000001_00010000);
        #1;
        a = 32'd6;
        b = 32'd7;
        waitDone(1, 0, "heldFirst");
        @(negedge clk);
        checkOutput("heldIdleGap", {busy, done}, 2'b00);
        @(negedge clk);
        checkOutput("heldReaccept", busy, 1'b1);
        expQ.push_back(64'd42);
        checkOutput("heldHoldDuringRun", {hi, lo}, 64'h00000001_00010000);
        start = 1'b0;
        waitDone(2, 1, "heldSecond");
        repeat (2) @(negedge clk);

        // Reset at iteration 10 abandons the operation with no done pulse.
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncResetClear", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        reset = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("noDoneAfterAbort", doneCnt, 0);
        checkOutput("hiloAfterAbort", {hi, lo}, 64'd0);

        applyStimulus(32'd7, 32'd9, 64'h00000000_0000003F, "mul7x9");

        checkOutput("queueDrained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_32bit.md
SEQ_MULTIPLIER_32BIT -- requirements
Module: seq_multiplier_32bit

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 32 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port `clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 Port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-005 Port `start`: input, 1 bit, request to begin a multiply; sampled only in IDLE.
REQ-006 Port `a`: input, 32 bits, unsigned multiplicand; sampled when `start` is accepted.
REQ-007 Port `b`: input, 32 bits, unsigned multiplier; sampled when `start` is accepted.
REQ-008 Port `busy`: output, 1 bit, high while an operation is iterating (state RUN).
REQ-009 Port `done`: output, 1 bit, single-cycle pulse marking hi/lo newly valid.
REQ-010 Port `hi`: output, 32 bits, upper half of the 64-bit product.
REQ-011 Port `lo`: output, 32 bits, lower half of the 64-bit product.

Function
REQ-012 The block SHALL compute the unsigned 64-bit product {hi,lo} = a*b (MIPS multu semantics) by iterative shift-add, one multiplier bit per cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at an edge: latch a into the multiplicand register, load product register P[63:0] = {32'h0, b}, clear the 6-bit iteration counter, go to RUN.
REQ-015 IDLE with start=0: remain in IDLE; P, hi, lo unchanged.
REQ-016 Each RUN edge: if P[0]=1, form {c, s} = P[63:32] + mcand (33-bit sum incl. carry-out); else {c, s} = {1'b0, P[63:32]}; then P <= {c, s, P[31:1]}; counter increments.
REQ-017 The carry-out c of the 32-bit add SHALL be retained as bit 63 after the shift; no product bit SHALL be lost.
REQ-018 On the RUN edge where the counter reaches 31 (the 32nd iteration), the state SHALL go to DONE, and hi/lo SHALL load the final P[63:32]/P[31:0].
REQ-019 DONE SHALL last exactly one cycle, with done=1; the next edge SHALL return to IDLE unconditionally.
REQ-020 Latency: a start accepted at edge E0 SHALL produce done=1 in the cycle after edge E32, i.e. 33 edges from acceptance to done.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both SHALL be 0 in IDLE.
REQ-022 start asserted in RUN or DONE SHALL be ignored, with no effect on state, counter, P, or outputs.
REQ-023 A new start is accepted only in IDLE, so at least one IDLE cycle SHALL separate done from the next acceptance.
REQ-024 hi/lo SHALL change only at the RUN-to-DONE edge and SHALL hold their value through IDLE and any later RUN until the next completion.
REQ-025 a and b SHALL be don't-care after acceptance; changes during RUN SHALL NOT affect the result.
REQ-026 Operands 0 or 1 SHALL take the full 33-edge latency, with no early termination.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, P=0, mcand=0, hi=0, lo=0, busy=0, done=0.
REQ-028 A reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL occur for it and hi/lo SHALL read 0.
REQ-029 start SHALL be ignored while reset=1; the first start is accepted at the first rising edge with reset=0.

Verification
REQ-030 a=3, b=5, start one cycle -> busy high 32 cycles, done pulse one cycle 33 edges after acceptance, hi=32'h00000000, lo=32'h0000000F.
REQ-031 a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises carry-out retention).
REQ-032 a=32'h12345678, b=0, then a=0, b=32'hDEADBEEF -> both give hi=lo=0 after the full 33-edge latency.
REQ-033 start held high continuously with changing a/b during RUN -> result equals the product of the operands at acceptance; the next acceptance occurs on the edge after DONE (IDLE), and hi/lo hold between operations.
REQ-034 reset pulsed at iteration 10 of a=7, b=9 -> asynchronous clear of all outputs to 0, no done pulse; a following a=7, b=9 run gives lo=32'h0000003F, hi=0.
